instruction_decode: RTL and testbench
=====================================

// Module: instruction_decode
// PURPOSE
//  RV32I decode stage, directly downstream of instruction fetch. Consumes the fetched
//  instruction word and its PC, then reads the 32x32 register file. Generates the
//  immediate and control flags. Registers everything into a one-entry decode/execute
//  output stage.
//  Owns the architectural register file. The writeback stage writes it through a dedicated port.
// PARAMETERS
//  XLEN      32  datapath width (only 32 supported)
//  NUM_REGS  32  register count (x0 hardwired to zero)
// PORTS
//  clk          in   1   rising-edge clock
//  rst          in   1   reset; synchronous, active-high
//  instr_in     in   32  instruction word from fetch
//  pc_in        in   32  PC of instr_in
//  stall        in   1   hold output stage (hazard/backpressure)
//  flush        in   1   replace next output with bubble (taken branch)
//  wb_en        in   1   register-file write enable
//  wb_rd        in   5   write address
//  wb_data      in   32  write data
//  pc_out       out  32  registered PC
//  rs1_data     out  32  registered rs1 value (0 for LUI)
//  rs2_data     out  32  registered rs2 value
//  imm          out  32  registered sign-extended immediate
//  rd           out  5   destination register
//  funct3       out  3   instr[14:12], passed through
//  alu_op       out  4   {alt,funct3}; alt=funct7[5] for OP, and for OP-IMM with funct3=101; else alt=0, funct3 as field
//  alu_src_imm  out  1   ALU B operand = imm
//  reg_write, mem_read, mem_write, branch, jump, pc_rel  out 1 each  control flags
//  illegal      out  1   unsupported opcode seen
// BEHAVIOUR
//  - Latency 1 cycle: outputs reflect instr_in/pc_in sampled at the previous posedge.
//  - Reset (rst=1 at posedge): all outputs 0, all 32 registers cleared. Reset overrides every other input.
//  - Priority per edge: rst > flush > stall > load.
//    - flush: output becomes a bubble (all control flags 0, rd=0, illegal=0; data outputs 0).
//    - stall (no flush): all outputs hold their values.
//  - Register-file write occurs at every posedge with wb_en=1 and wb_rd!=0, regardless of stall/flush.
//    Writes to x0 are discarded; x0 always reads 0.
//  - Register-file read is combinational from instr_in[19:15]/[24:20]; the value is captured into rs*_data.
//  - Immediate formats:
//    - I: LOAD, OP-IMM, JALR
//    - S: STORE
//    - B: BRANCH, bit0=0
//    - U: LUI, AUIPC, low 12 bits=0
//    - J: JAL, bit0=0
//    - All formats sign-extended from instr[31]. OP gives imm=0.
//  - Opcode table (flags asserted; all others 0):
//    - 0110111 LUI: reg_write, alu_src_imm
//    - 0010111 AUIPC: reg_write, alu_src_imm, pc_rel
//    - 1101111 JAL: reg_write, jump, pc_rel
//    - 1100111 JALR: reg_write, jump, alu_src_imm
//    - 1100011 BRANCH: branch, pc_rel
//    - 0000011 LOAD: reg_write, mem_read, alu_src_imm
//    - 0100011 STORE: mem_write, alu_src_imm
//    - 0010011 OP-IMM: reg_write, alu_src_imm
//    - 0110011 OP: reg_write
//  - Any other opcode: bubble control with illegal=1 for that one output cycle; rd=0.
//  - Instructions that do not write a register (store, branch, illegal) output rd=0.
// CONFIGURATION
//  DECODE_WB_BYPASS_EN
//    - Defined: a same-cycle write to the register being read (wb_en, wb_rd!=0, wb_rd==rs1/rs2)
//      forwards wb_data into rs1_data/rs2_data.
//    - Undefined: the stale pre-write value is captured; the write is visible to reads in the
//      following cycle. Upstream hazard logic must then stall one extra cycle.
// TESTING
//  1. rst high 2 cycles then instr_in=0x00500093 (addi x1,x0,5)
//     -> next cycle: rd=1, imm=5, reg_write=1, alu_src_imm=1, rs1_data=0.
//  2. wb x1=0xDEADBEEF, wb x2=0x00000010; then instr_in=0x002081B3 (add x3,x1,x2)
//     -> rs1_data=0xDEADBEEF, rs2_data=0x10, rd=3, alu_op=0000.
//  3. instr_in=0xFE000EE3 (beq x0,x0,-4), pc_in=0x100
//     -> imm=0xFFFFFFFC, branch=1, pc_rel=1, reg_write=0, pc_out=0x100.
//  4. wb_en=1, wb_rd=0, wb_data=0x1234, then read x0 -> rs1_data=0.
//     Same-cycle wb x5 while decoding a read of x5 -> new value with _EN, old without.
//  5. instr_in=0xFFFFFFFF -> illegal=1 and all control flags 0 for one cycle;
//     next legal instruction clears illegal.
//  6. Load addi, assert stall 3 cycles while instr_in changes -> outputs frozen.
//     Assert flush+stall together -> bubble. Assert rst mid-stall -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/instruction_decode.sv
// RV32I decode stage: owns the 32x32 register file and registers decoded
// fields into a one-entry output stage. Optional macro: DECODE_WB_BYPASS_EN.
module instruction_decode #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic            pc_rel,
    output logic            illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic pc_rel;
        logic alu_src_imm;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [3:0]      alu_op;
        ctrl_t           ctrl;
    } dec_t;

    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rf_rs1, rf_rs2;
    ctrl_t           ctrl_d;
    logic [XLEN-1:0] imm_d;
    logic            alt;
    dec_t            dec_d;
    dec_t            dec_q;

    assign opcode   = instr_in[6:0];
    assign f3       = instr_in[14:12];
    assign rs1_addr = instr_in[19:15];
    assign rs2_addr = instr_in[24:20];

    assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
    assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                    instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u = {instr_in[31:12], 12'b0};
    assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                    instr_in[20], instr_in[30:21], 1'b0};

    always_comb begin
        ctrl_d = '0;
        imm_d  = '0;
        alt    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                imm_d = imm_u;
            end
            OPC_AUIPC: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_imm = 1'b1; ctrl_d.pc_rel = 1'b1;
                imm_d = imm_u;
            end
            OPC_JAL: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.pc_rel = 1'b1;
                imm_d = imm_j;
            end
            OPC_JALR: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.jump = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                imm_d = imm_i;
            end
            OPC_BRANCH: begin
                ctrl_d.branch = 1'b1; ctrl_d.pc_rel = 1'b1;
                imm_d = imm_b;
            end
            OPC_LOAD: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.mem_read = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                imm_d = imm_i;
            end
            OPC_STORE: begin
                ctrl_d.mem_write = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                imm_d = imm_s;
            end
            OPC_OPIMM: begin
                ctrl_d.reg_write = 1'b1; ctrl_d.alu_src_imm = 1'b1;
                imm_d = imm_i;
                // only shift-right distinguishes logical/arithmetic via funct7[5]
                alt = (f3 == 3'b101) ? instr_in[30] : 1'b0;
            end
            OPC_OP: begin
                ctrl_d.reg_write = 1'b1;
                alt = instr_in[30];
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        rf_rs1 = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
        rf_rs2 = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs1_addr) rf_rs1 = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd == rs2_addr) rf_rs2 = wb_data;
    end
`else
    // Same-cycle writes are not visible here; upstream must stall an extra cycle.
    assign rf_rs1 = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
    assign rf_rs2 = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
`endif

    always_comb begin
        dec_d        = '0;
        dec_d.pc     = pc_in;
        dec_d.rs1    = (opcode == OPC_LUI) ? '0 : rf_rs1;
        dec_d.rs2    = rf_rs2;
        dec_d.imm    = imm_d;
        dec_d.rd     = ctrl_d.reg_write ? instr_in[11:7] : 5'd0;
        dec_d.funct3 = f3;
        dec_d.alu_op = ctrl_d.illegal ? 4'd0 : {alt, f3};
        dec_d.ctrl   = ctrl_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            dec_q <= '0;
        else if (!stall)
            dec_q <= dec_d;
    end

    assign pc_out      = dec_q.pc;
    assign rs1_data    = dec_q.rs1;
    assign rs2_data    = dec_q.rs2;
    assign imm         = dec_q.imm;
    assign rd          = dec_q.rd;
    assign funct3      = dec_q.funct3;
    assign alu_op      = dec_q.alu_op;
    assign alu_src_imm = dec_q.ctrl.alu_src_imm;
    assign reg_write   = dec_q.ctrl.reg_write;
    assign mem_read    = dec_q.ctrl.mem_read;
    assign mem_write   = dec_q.ctrl.mem_write;
    assign branch      = dec_q.ctrl.branch;
    assign jump        = dec_q.ctrl.jump;
    assign pc_rel      = dec_q.ctrl.pc_rel;
    assign illegal     = dec_q.ctrl.illegal;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed self-checking bench for instruction_decode.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst, stall, flush, wb_en;
    logic [31:0] instr_in, pc_in, wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] pc_out, rs1_data, rs2_data, imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump, pc_rel, illegal;

    int asserts  = 0;
    int failures = 0;

    instruction_decode dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .pc_out(pc_out), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .rd(rd),
        .funct3(funct3), .alu_op(alu_op), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .pc_rel(pc_rel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] flags();
        return {reg_write, mem_read, mem_write, branch, jump, pc_rel, alu_src_imm, illegal};
    endfunction

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
        instr_in = 32'h00500093; pc_in = 32'h44;
        step(); step();
        asserts++; if (flags() !== 8'h00) begin failures++; $display("FAIL reset_flags got %h exp 00", flags()); end
        asserts++; if ({pc_out, imm, rs1_data, rs2_data} !== 128'd0) begin failures++; $display("FAIL reset_data got %h %h %h %h exp 0", pc_out, imm, rs1_data, rs2_data); end
        asserts++; if ({rd, funct3, alu_op} !== 12'd0) begin failures++; $display("FAIL reset_fields got %h exp 0", {rd, funct3, alu_op}); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        instr_in = 32'h00500093; pc_in = 32'h0;
        step();
        asserts++; if (rd !== 5'd1) begin failures++; $display("FAIL addi_rd got %0d exp 1", rd); end
        asserts++; if (imm !== 32'd5) begin failures++; $display("FAIL addi_imm got %h exp 5", imm); end
        asserts++; if (flags() !== 8'b1000_0010) begin failures++; $display("FAIL addi_flags got %b exp 10000010", flags()); end
        asserts++; if (rs1_data !== 32'd0) begin failures++; $display("FAIL addi_rs1 got %h exp 0", rs1_data); end
    endtask

    task automatic test_op();
        instr_in = 32'h00000013;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEADBEEF; step();
        wb_rd = 5'd2; wb_data = 32'h00000010; step();
        wb_en = 1'b0;
        instr_in = 32'h002081B3; step();
        asserts++; if (rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL add_rs1 got %h exp deadbeef", rs1_data); end
        asserts++; if (rs2_data !== 32'h10) begin failures++; $display("FAIL add_rs2 got %h exp 10", rs2_data); end
        asserts++; if ({rd, alu_op} !== {5'd3, 4'b0000}) begin failures++; $display("FAIL add_rd_aluop got %0d %b exp 3 0000", rd, alu_op); end
        asserts++; if ({flags(), imm} !== {8'b1000_0000, 32'd0}) begin failures++; $display("FAIL add_flags_imm got %b %h exp 10000000 0", flags(), imm); end
        instr_in = 32'h40208233; step();  // sub x4,x1,x2
        asserts++; if ({rd, alu_op} !== {5'd4, 4'b1000}) begin failures++; $display("FAIL sub_rd_aluop got %0d %b exp 4 1000", rd, alu_op); end
        instr_in = 32'h4030D293; step();  // srai x5,x1,3
        asserts++; if ({alu_op, funct3, imm} !== {4'b1101, 3'b101, 32'h403}) begin failures++; $display("FAIL srai got %b %b %h exp 1101 101 403", alu_op, funct3, imm); end
    endtask

    task automatic test_formats();
        instr_in = 32'hFE000EE3; pc_in = 32'h100; step();
        asserts++; if (imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL beq_imm got %h exp fffffffc", imm); end
        asserts++; if ({flags(), rd} !== {8'b0001_0100, 5'd0}) begin failures++; $display("FAIL beq_flags got %b rd %0d exp 00010100 0", flags(), rd); end
        asserts++; if (pc_out !== 32'h100) begin failures++; $display("FAIL beq_pc got %h exp 100", pc_out); end
        instr_in = 32'h0020A423; pc_in = 32'h104; step();  // sw x2,8(x1)
        asserts++; if ({imm, rd, rs2_data} !== {32'd8, 5'd0, 32'h10}) begin failures++; $display("FAIL sw got imm %h rd %0d rs2 %h exp 8 0 10", imm, rd, rs2_data); end
        asserts++; if (flags() !== 8'b0010_0010) begin failures++; $display("FAIL sw_flags got %b exp 00100010", flags()); end
        instr_in = 32'hFFF083B7; step();  // lui x7,0xfff08 (rs1 field = x1)
        asserts++; if ({imm, rd, rs1_data} !== {32'hFFF08000, 5'd7, 32'd0}) begin failures++; $display("FAIL lui got imm %h rd %0d rs1 %h exp fff08000 7 0", imm, rd, rs1_data); end
        instr_in = 32'h008000EF; step();  // jal x1,+8
        asserts++; if ({imm, rd, flags()} !== {32'd8, 5'd1, 8'b1000_1100}) begin failures++; $display("FAIL jal got imm %h rd %0d flags %b exp 8 1 10001100", imm, rd, flags()); end
    endtask

    task automatic test_x0_and_bypass();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234; instr_in = 32'h00000013; step();
        wb_en = 1'b0; instr_in = 32'h00000033; step();
        asserts++; if ({rs1_data, rs2_data} !== 64'd0) begin failures++; $display("FAIL x0_read got %h %h exp 0", rs1_data, rs2_data); end
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA0001; step();
        instr_in = 32'h00028313; wb_data = 32'h55550002; step();  // addi x6,x5,0 with same-cycle wb x5
`ifdef DECODE_WB_BYPASS_EN
        asserts++; if (rs1_data !== 32'h55550002) begin failures++; $display("FAIL bypass got %h exp 55550002", rs1_data); end
`else
        asserts++; if (rs1_data !== 32'hAAAA0001) begin failures++; $display("FAIL nobypass got %h exp aaaa0001", rs1_data); end
`endif
        wb_en = 1'b0; step();
        asserts++; if (rs1_data !== 32'h55550002) begin failures++; $display("FAIL wb_next got %h exp 55550002", rs1_data); end
    endtask

    task automatic test_illegal();
        instr_in = 32'hFFFFFFFF; step();
        asserts++; if ({flags(), rd} !== {8'b0000_0001, 5'd0}) begin failures++; $display("FAIL illegal got %b rd %0d exp 00000001 0", flags(), rd); end
        instr_in = 32'h00500093; step();
        asserts++; if (flags() !== 8'b1000_0010) begin failures++; $display("FAIL illegal_clear got %b exp 10000010", flags()); end
    endtask

    task automatic test_stall_flush_reset();
        instr_in = 32'h00500093; pc_in = 32'h200; step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_in = 32'h002081B3 + 32'(i << 7); pc_in = 32'h300 + 32'(i); step();
            asserts++; if ({rd, imm, pc_out, flags()} !== {5'd1, 32'd5, 32'h200, 8'b1000_0010}) begin failures++; $display("FAIL stall_hold%0d got rd %0d imm %h pc %h exp 1 5 200", i, rd, imm, pc_out); end
        end
        flush = 1'b1; step();
        asserts++; if ({flags(), rd, imm, pc_out} !== 77'd0) begin failures++; $display("FAIL flush_bubble got %b %0d %h %h exp 0", flags(), rd, imm, pc_out); end
        flush = 1'b0; stall = 1'b0; instr_in = 32'h00500093; step();
        stall = 1'b1; step();
        asserts++; if (rd !== 5'd1) begin failures++; $display("FAIL restall got %0d exp 1", rd); end
        rst = 1'b1; step();
        asserts++; if ({flags(), rd, imm, pc_out, rs1_data} !== 109'd0) begin failures++; $display("FAIL rst_mid_stall got %b %0d %h %h exp 0", flags(), rd, imm, pc_out); end
        rst = 1'b0; stall = 1'b0; instr_in = 32'h002081B3; step();
        asserts++; if ({rs1_data, rs2_data} !== 64'd0) begin failures++; $display("FAIL rf_cleared got %h %h exp 0", rs1_data, rs2_data); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_op();
        test_formats();
        test_x0_and_bypass();
        test_illegal();
        test_stall_flush_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
